regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with write-back bypass, per-register busy scoreboard and a difftest snapshot port. It serves the decode/write-back boundary of the core. It supports several read and write ports so a dual-issue pipeline can share one architectural state. It also tracks in-flight producers so decode can stall on RAW hazards without a separate scoreboard.

## Interface
Parameters:
- `XLEN`, 64, register width in bits
- `NREG`, 32, number of architectural registers (power of two, ≥2); `AW = $clog2(NREG)`
- `NRD`, 2, number of read ports
- `NWR`, 2, number of write ports; higher index has priority

Ports:
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `WriteEnable` in NWR: per-port write strobe
- `WriteAddr` in NWR*AW: packed write addresses, port k at `[k*AW +: AW]`
- `WriteData` in NWR*XLEN: packed write data
- `ReadEnable` in NRD: per-port read strobe
- `ReadAddr` in NRD*AW: packed read addresses
- `ReadData` out NRD*XLEN: packed read data
- `ReadBusy` out NRD: addressed register has an outstanding producer
- `AllocEnable` in 1: mark `AllocAddr` busy (decode issued a writer)
- `AllocAddr` in AW: destination being allocated
- `regs_o` out NREG*XLEN: flattened architectural state for difftest, reg i at `[i*XLEN +: XLEN]`

## Operation
- Storage: `NREG` × `XLEN` flops. Register 0 is hard-wired zero. Writes to it are dropped. It is never busy and always reads 0.
- Write resolution per cycle: for each register, the highest-index port k with `WriteEnable[k]` and a matching address wins. Lower ports to the same address are discarded.
- Read port j:
  - Outputs 0 if `rst`, `!ReadEnable[j]`, or address 0.
  - Else, if any enabled write port targets the same address, outputs the winning port's `WriteData` (bypass).
  - Else outputs the stored value.
  - Bypass is gated by `WriteEnable`. A matching address with no enable does not forward.
- Scoreboard, one busy bit per register (bit 0 constant 0):
  - Set by `AllocEnable` at `AllocAddr`.
  - Cleared by any enabled write to that address.
  - Alloc and write to the same address in the same cycle: the bit ends **set**, because the new producer wins.
  - Alloc to address 0 is ignored.
- `ReadBusy[j]` = `busy[ReadAddr[j]] & ReadEnable[j]`, taken from the registered busy bit. It is forced 0 when the same-cycle write bypass supplies the data.
- `regs_o[i]` shows the post-write view. If a write to i (i≠0) is enabled this cycle, it shows the winning data; otherwise the stored value. This lets difftest compare at commit time.

## Timing
- Reset (`rst` high at posedge):
  - All registers become 0 and all busy bits 0.
  - While `rst` is high, `ReadData`, `ReadBusy` and `regs_o` are combinationally 0.
  - Writes and allocs presented during reset are dropped.
- Write latency: stored on the posedge that samples `WriteEnable`. Visible the same cycle through the bypass, and from storage on the next cycle.
- Read latency: combinational, zero cycles.
- Busy set/clear take effect on the next posedge. The alloc cycle itself still reads busy=0 unless the register was already busy.
- Reset asserted mid-stream clears all outstanding busy bits. Producers still in flight will write afterwards, and those writes are accepted normally.

## Structure
- Shared package `regfile_pkg`:
  - `XLEN_DEFAULT` and `NREG_DEFAULT`
  - `ZERO_XLEN` constant
  - function `pick_write(en, addr, target)` returning winning port index and hit flag; reused by storage, bypass and `regs_o`.
- Sub-module `reg_scoreboard` (params `NREG`; ports `clk`, `rst`, alloc, per-port write clear, busy vector out). The top instantiates one and indexes the busy vector per read port.

## Test plan
- Reset then read: `rst` 1 cycle, `ReadEnable`=all, `ReadAddr`=5,31 -> `ReadData`=0,0; `ReadBusy`=0; `regs_o`=all 0.
- Write/readback: cycle 0 write port0 x5=0xDEAD_BEEF; cycle 1 read x5 -> 0xDEAD_BEEF.
- Same-cycle bypass with ungated match: port1 writes x7=0x1234 enabled, read x7 -> 0x1234. Next cycle port1 addr=7 data=0x9999 with `WriteEnable`=0 -> read returns 0x1234.
- Write conflict and x0:
  - Ports 0 and 1 both write x3 with 0xAA and 0xBB -> x3=0xBB.
  - Write x0=0xFF -> read x0=0, `regs_o[0]`=0.
- Scoreboard:
  - Alloc x9 -> next cycle `ReadBusy`=1.
  - Write x9=0x42 -> same cycle `ReadBusy`=0, `ReadData`=0x42; next cycle busy=0.
  - Alloc+write x9 same cycle -> busy=1 afterwards.
- Reset mid-operation: alloc x4, x6, write x4=0x55, assert `rst` -> all busy 0, x4 reads 0 after reset; a write x6=0x77 after reset -> reads 0x77.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and the write-port arbitration helper for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int NREG_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] ZERO_XLEN = '0;

    // Arbitration works on a fixed maximum port count / address width; callers zero-extend.
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 16;
    localparam int IDX_W  = $clog2(MAX_WR);

    typedef logic [MAX_WR-1:0]             wr_en_t;
    typedef logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } wr_pick_t;

    // Highest-index enabled port whose address matches target wins.
    function automatic wr_pick_t pick_write(input wr_en_t en, input wr_addr_t addr,
                                            input logic [MAX_AW-1:0] target);
        wr_pick_t p;
        p = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (en[k] && addr[k] == target) begin
                p.hit = 1'b1;
                p.idx = IDX_W'(k);
            end
        end
        return p;
    endfunction

    function automatic logic write_hit(input wr_en_t en, input wr_addr_t addr,
                                       input logic [MAX_AW-1:0] target);
        wr_pick_t p;
        p = pick_write(en, addr, target);
        return p.hit;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by decode allocation, cleared by write-back; register 0 never busy.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_addr,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    output logic [NREG-1:0]         busy
);

    logic [NREG-1:0] busy_d;

    // Alloc is applied after the clears so a same-cycle new producer keeps the bit set.
    always_comb begin
        busy_d = busy;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k]) busy_d[wr_addr[k]] = 1'b0;
        end
        if (alloc_en) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_d;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, busy scoreboard and
// a post-write architectural snapshot for difftest.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        WriteEnable,
    input  logic [NWR*AW-1:0]     WriteAddr,
    input  logic [NWR*XLEN-1:0]   WriteData,
    input  logic [NRD-1:0]        ReadEnable,
    input  logic [NRD*AW-1:0]     ReadAddr,
    output logic [NRD*XLEN-1:0]   ReadData,
    output logic [NRD-1:0]        ReadBusy,
    input  logic                  AllocEnable,
    input  logic [AW-1:0]         AllocAddr,
    output logic [NREG*XLEN-1:0]  regs_o
);

    logic [NWR-1:0][XLEN-1:0] wd;
    logic [NWR-1:0][AW-1:0]   wa;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    wr_en_t                   we_ext;
    wr_addr_t                 wa_ext;
    logic [NREG-1:0]          busy;
    logic [XLEN-1:0]          post [NREG];

    assign wd      = WriteData;
    assign wa      = WriteAddr;
    assign rd_addr = ReadAddr;

    always_comb begin
        we_ext = '0;
        wa_ext = '0;
        for (int k = 0; k < NWR; k++) begin
            we_ext[k] = WriteEnable[k];
            wa_ext[k] = MAX_AW'(wa[k]);
        end
    end

    reg_scoreboard #(.NREG(NREG), .NWR(NWR), .AW(AW)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (AllocEnable),
        .alloc_addr (AllocAddr),
        .wr_en      (WriteEnable),
        .wr_addr    (wa),
        .busy       (busy)
    );

    // post[i] is the value register i holds after this cycle's writes.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign post[i] = XLEN'(ZERO_XLEN);
        end else begin : g_live
            logic [XLEN-1:0] q;
            logic [XLEN-1:0] wsel;
            wr_pick_t        pk;

            always_comb begin
                pk   = pick_write(we_ext, wa_ext, MAX_AW'(i));
                wsel = '0;
                for (int k = 0; k < NWR; k++) begin
                    if (pk.idx == IDX_W'(k)) wsel = wd[k];
                end
            end

            always_ff @(posedge clk) begin
                if (rst)         q <= '0;
                else if (pk.hit) q <= wsel;
            end

            assign post[i] = pk.hit ? wsel : q;
        end
    end

    always_comb begin
        regs_o = '0;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_o[i*XLEN +: XLEN] = post[i];
        end
    end

    // A bypassed read is satisfied this cycle, so it must not report busy.
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        for (int j = 0; j < NRD; j++) begin
            if (!rst && ReadEnable[j] && rd_addr[j] != '0) begin
                ReadData[j*XLEN +: XLEN] = post[rd_addr[j]];
                ReadBusy[j] = busy[rd_addr[j]] &&
                              !write_hit(we_ext, wa_ext, MAX_AW'(rd_addr[j]));
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised + directed bench for regfile_mp; expectations queued by the driver, checked by a monitor.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NWR-1:0]       WriteEnable;
    logic [NWR*AW-1:0]    WriteAddr;
    logic [NWR*XLEN-1:0]  WriteData;
    logic [NRD-1:0]       ReadEnable;
    logic [NRD*AW-1:0]    ReadAddr;
    logic [NRD*XLEN-1:0]  ReadData;
    logic [NRD-1:0]       ReadBusy;
    logic                 AllocEnable;
    logic [AW-1:0]        AllocAddr;
    logic [NREG*XLEN-1:0] regs_o;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .ReadEnable  (ReadEnable),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .ReadBusy    (ReadBusy),
        .AllocEnable (AllocEnable),
        .AllocAddr   (AllocAddr),
        .regs_o      (regs_o)
    );

    typedef struct {
        logic [XLEN-1:0] rd [NRD];
        logic [NRD-1:0]  bsy;
        logic [XLEN-1:0] regs [NREG];
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;

    // Reference model: architectural values and busy flags as plain arrays.
    logic [XLEN-1:0] mem [NREG];
    bit              bsy_m [NREG];
    bit              we_c [NWR];
    int              wa_c [NWR];
    logic [XLEN-1:0] wd_c [NWR];

    function automatic bit fwd(input int a, output logic [XLEN-1:0] d);
        for (int k = NWR - 1; k >= 0; k--) begin
            if (we_c[k] && wa_c[k] == a) begin
                d = wd_c[k];
                return 1'b1;
            end
        end
        d = '0;
        return 1'b0;
    endfunction

    task automatic step(input bit r, input bit [1:0] we,
                        input bit [AW-1:0] wa0, input bit [XLEN-1:0] wd0,
                        input bit [AW-1:0] wa1, input bit [XLEN-1:0] wd1,
                        input bit [1:0] re, input bit [AW-1:0] ra0, input bit [AW-1:0] ra1,
                        input bit ae, input bit [AW-1:0] aa);
        exp_t            e;
        int              ra [NRD];
        logic [XLEN-1:0] d;
        bit              h;
        rst         = r;
        WriteEnable = we;
        WriteAddr   = {wa1, wa0};
        WriteData   = {wd1, wd0};
        ReadEnable  = re;
        ReadAddr    = {ra1, ra0};
        AllocEnable = ae;
        AllocAddr   = aa;
        we_c[0] = we[0]; wa_c[0] = int'(wa0); wd_c[0] = wd0;
        we_c[1] = we[1]; wa_c[1] = int'(wa1); wd_c[1] = wd1;
        ra[0] = int'(ra0);
        ra[1] = int'(ra1);
        for (int j = 0; j < NRD; j++) begin
            e.rd[j]  = '0;
            e.bsy[j] = 1'b0;
            if (!r && re[j] && ra[j] != 0) begin
                h        = fwd(ra[j], d);
                e.rd[j]  = h ? d : mem[ra[j]];
                e.bsy[j] = bsy_m[ra[j]] && !h;
            end
        end
        for (int i = 0; i < NREG; i++) begin
            h         = fwd(i, d);
            e.regs[i] = (r || i == 0) ? '0 : (h ? d : mem[i]);
        end
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i]   = '0;
                bsy_m[i] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we_c[k] && wa_c[k] != 0) begin
                    mem[wa_c[k]]   = wd_c[k];
                    bsy_m[wa_c[k]] = 1'b0;
                end
            end
            if (ae && aa != 0) bsy_m[aa] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_read(input bit [AW-1:0] ra0, input bit [AW-1:0] ra1);
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, ra0, ra1, 0, 0);
    endtask

    // Monitor: outputs are combinational, so every negedge presents one response.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            for (int j = 0; j < NRD; j++) begin
                total++;
                if (ReadData[j*XLEN +: XLEN] !== me.rd[j]) begin
                    bad++;
                    $display("FAIL rdata%0d t=%0t got=%h want=%h", j, $time,
                             ReadData[j*XLEN +: XLEN], me.rd[j]);
                end
                total++;
                if (ReadBusy[j] !== me.bsy[j]) begin
                    bad++;
                    $display("FAIL rbusy%0d t=%0t got=%b want=%b", j, $time,
                             ReadBusy[j], me.bsy[j]);
                end
            end
            for (int i = 0; i < NREG; i++) begin
                total++;
                if (regs_o[i*XLEN +: XLEN] !== me.regs[i]) begin
                    bad++;
                    $display("FAIL regs_o[%0d] t=%0t got=%h want=%h", i, $time,
                             regs_o[i*XLEN +: XLEN], me.regs[i]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREG; i++) begin
            mem[i]   = '0;
            bsy_m[i] = 1'b0;
        end
        rst = 1'b1; WriteEnable = '0; WriteAddr = '0; WriteData = '0;
        ReadEnable = '0; ReadAddr = '0; AllocEnable = 1'b0; AllocAddr = '0;
        @(posedge clk); #1;

        // reset then read
        step(1, 2'b00, 0, 0, 0, 0, 2'b11, 5, 31, 0, 0);
        // write / readback
        step(0, 2'b01, 5, 64'hDEAD_BEEF, 0, 0, 2'b00, 0, 0, 0, 0);
        idle_read(5, 31);
        // bypass, then ungated match must not forward
        step(0, 2'b10, 0, 0, 7, 64'h1234, 2'b01, 7, 0, 0, 0);
        step(0, 2'b00, 0, 0, 7, 64'h9999, 2'b11, 7, 7, 0, 0);
        // write conflict: higher port wins
        step(0, 2'b11, 3, 64'hAA, 3, 64'hBB, 2'b11, 3, 3, 0, 0);
        idle_read(3, 5);
        // x0 is hard-wired zero
        step(0, 2'b01, 0, 64'hFF, 0, 0, 2'b11, 0, 0, 0, 0);
        idle_read(0, 3);
        // scoreboard set / bypass-clear / alloc-beats-write
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 1, 9);
        idle_read(9, 3);
        step(0, 2'b01, 9, 64'h42, 0, 0, 2'b11, 9, 3, 0, 0);
        idle_read(9, 9);
        step(0, 2'b10, 0, 0, 9, 64'h43, 2'b01, 9, 0, 1, 9);
        idle_read(9, 9);
        // alloc to x0 ignored
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        idle_read(0, 9);
        // reset mid-operation
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 4);
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, 4, 6, 1, 6);
        step(0, 2'b01, 4, 64'h55, 0, 0, 2'b11, 4, 6, 0, 0);
        step(1, 2'b11, 6, 64'h11, 4, 64'h22, 2'b11, 4, 6, 1, 6);
        idle_read(4, 6);
        step(0, 2'b01, 6, 64'h77, 0, 0, 2'b00, 0, 0, 0, 0);
        idle_read(6, 4);

        // random traffic, addresses biased low to force conflicts and bypasses
        for (int n = 0; n < 400; n++) begin
            bit [AW-1:0] a [5];
            for (int m = 0; m < 5; m++)
                a[m] = ($urandom_range(3) == 0) ? AW'($urandom_range(31)) : AW'($urandom_range(7));
            step($urandom_range(39) == 0, 2'($urandom),
                 a[0], {$urandom, $urandom}, a[1], {$urandom, $urandom},
                 2'($urandom), a[2], a[3], 1'($urandom), a[4]);
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
